// File: rtl/regf_access_ctrl.sv
// Register-file access controller: single or burst reads/writes behind valid/ready handshakes.
// Optional feature: define REGF_ACCESS_BURST_EN to honour cmd_len (1-16 beats); otherwise every command is one beat.
`timescale 1ns/1ps
module regf_access_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rnw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              regf_wr_en,
  output logic              regf_rd_en,
  output logic [ADDR_W-1:0] regf_wr_addr,
  output logic [ADDR_W-1:0] regf_rd_addr,
  output logic [DATA_W-1:0] regf_data_in,
  input  logic [DATA_W-1:0] regf_data_out,
  output logic              busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR       = 3'd1;
  localparam logic [2:0] RD_ISSUE = 3'd2;
  localparam logic [2:0] RD_WAIT  = 3'd3;
  localparam logic [2:0] RD_RESP  = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_r, state_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic [DATA_W-1:0] rsp_data_r, rsp_data_nxt_s;
  logic              cmd_ready_r;
  logic [3:0]        len_s;
  logic              wr_beat_s;

`ifdef REGF_ACCESS_BURST_EN
  assign len_s = cmd_len;
`else
  logic unused_len_s;
  assign unused_len_s = ^cmd_len;
  assign len_s        = 4'd0;
`endif

  assign wr_beat_s = (state_r == WR) && wd_valid;

  // Next-state, address, beat counter and response-data computation.
  always_comb begin
    state_nxt_s    = state_r;
    addr_nxt_s     = addr_r;
    cnt_nxt_s      = cnt_r;
    rsp_data_nxt_s = rsp_data_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          addr_nxt_s  = cmd_addr;
          cnt_nxt_s   = len_s;
          state_nxt_s = cmd_rnw ? RD_ISSUE : WR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR: begin
        if (wr_beat_s) begin
          addr_nxt_s = addr_r + ADDR_ONE;
          if (cnt_r == 4'd0) begin
            state_nxt_s = IDLE;
          end else begin
            cnt_nxt_s = cnt_r - 4'd1;
          end
        end else begin
          state_nxt_s = WR;
        end
      end
      RD_ISSUE: begin
        state_nxt_s = RD_WAIT;
      end
      RD_WAIT: begin
        rsp_data_nxt_s = regf_data_out;
        state_nxt_s    = RD_RESP;
      end
      RD_RESP: begin
        // rsp_data/rsp_last stay frozen until the consumer takes the beat.
        if (rsp_ready) begin
          addr_nxt_s = addr_r + ADDR_ONE;
          if (cnt_r == 4'd0) begin
            state_nxt_s = IDLE;
          end else begin
            cnt_nxt_s   = cnt_r - 4'd1;
            state_nxt_s = RD_ISSUE;
          end
        end else begin
          state_nxt_s = RD_RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      cnt_r       <= 4'd0;
      rsp_data_r  <= {DATA_W{1'b0}};
      cmd_ready_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      addr_r      <= addr_nxt_s;
      cnt_r       <= cnt_nxt_s;
      rsp_data_r  <= rsp_data_nxt_s;
      cmd_ready_r <= (state_nxt_s == IDLE);
    end
  end

  // Write strobe and data pass straight through so a beat lands in the cycle it is offered.
  assign cmd_ready    = cmd_ready_r;
  assign wd_ready     = (state_r == WR);
  assign regf_wr_en   = wr_beat_s;
  assign regf_wr_addr = addr_r;
  assign regf_data_in = wr_beat_s ? wd_data : {DATA_W{1'b0}};
  assign regf_rd_en   = (state_r == RD_ISSUE);
  assign regf_rd_addr = addr_r;
  assign rsp_valid    = (state_r == RD_RESP);
  assign rsp_data     = rsp_data_r;
  assign rsp_last     = (state_r == RD_RESP) && (cnt_r == 4'd0);
  assign busy         = (state_r != IDLE);

endmodule

// File: tb/tb_regf_access_ctrl.sv
// Self-checking bench for regf_access_ctrl: directed table, reset-abort sequence and random commands
// checked against an array model of the register file.
`timescale 1ns/1ps
module tb_regf_access_ctrl;

`ifdef REGF_ACCESS_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
  logic [3:0] cmd_addr = 4'd0, cmd_len = 4'd0;
  logic       wd_valid = 1'b0, wd_ready;
  logic [7:0] wd_data = 8'd0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_last;
  logic [7:0] rsp_data;
  logic       regf_wr_en, regf_rd_en;
  logic [3:0] regf_wr_addr, regf_rd_addr;
  logic [7:0] regf_data_in, regf_data_out;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] env_mem [16];
  logic [7:0] ref_mem [16];

  regf_access_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .regf_wr_en(regf_wr_en), .regf_rd_en(regf_rd_en),
    .regf_wr_addr(regf_wr_addr), .regf_rd_addr(regf_rd_addr),
    .regf_data_in(regf_data_in), .regf_data_out(regf_data_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Register-file environment: write on strobe, read data valid the cycle after regf_rd_en.
  always @(posedge clk) begin
    if (regf_wr_en) env_mem[regf_wr_addr] <= regf_data_in;
    if (regf_rd_en) regf_data_out <= env_mem[regf_rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int beats_of(input int len);
    return BURST ? (len + 1) : 1;
  endfunction

  // Present a command once cmd_ready is seen; returns at the negedge after acceptance.
  task automatic issue_cmd(input bit rnw, input int addr, input int len);
    int cyc = 0;
    while (cmd_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_rnw   = rnw;
    cmd_addr  = addr[3:0];
    cmd_len   = len[3:0];
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    check("busy_after_cmd", {31'd0, busy}, 32'd1);
  endtask

  // dbase >= 0 gives beat data dbase, dbase+1, ...; otherwise random data.
  task automatic do_write(input int addr, input int len, input int dbase, input int exp_beats);
    int cnt = 0;
    int cyc = 0;
    int ea;
    logic [7:0] d;
    issue_cmd(1'b0, addr, len);
    while (cyc < 200) begin
      wd_valid = ($urandom_range(0, 2) != 0);
      d = (dbase >= 0) ? 8'(dbase + cnt) : 8'($urandom);
      wd_data = d;
      #1;
      if (!busy) begin
        check("idle_wd_ignored", {31'd0, regf_wr_en}, 32'd0);
        check("idle_wd_ready", {31'd0, wd_ready}, 32'd0);
        break;
      end
      check("wd_ready", {31'd0, wd_ready}, 32'd1);
      check("wr_en", {31'd0, regf_wr_en}, {31'd0, wd_valid});
      check("rd_en_in_wr", {31'd0, regf_rd_en}, 32'd0);
      if (wd_valid) begin
        ea = (addr + cnt) % 16;
        check("wr_addr", {28'd0, regf_wr_addr}, ea);
        check("wr_data", {24'd0, regf_data_in}, {24'd0, d});
        ref_mem[ea] = d;
        cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    wd_valid = 1'b0;
    check("wr_timeout", {31'd0, (cyc >= 200)}, 32'd0);
    check("wr_beats", cnt, exp_beats);
    check("wr_idle_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic do_read(input int addr, input int len, input int hold, input int exp_beats);
    int cnt = 0;
    int cyc = 0;
    int ea;
    issue_cmd(1'b1, addr, len);
    wd_valid = 1'b1;
    while (cyc < 400) begin
      #1;
      if (!busy) break;
      check("rd_issue", {31'd0, regf_rd_en}, 32'd1);
      if (regf_rd_en) begin
        ea = (addr + cnt) % 16;
        check("rd_addr", {28'd0, regf_rd_addr}, ea);
        check("wr_en_in_rd", {31'd0, regf_wr_en}, 32'd0);
        check("rsp_valid_issue", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("rsp_valid_wait", {31'd0, rsp_valid}, 32'd0);
        check("rd_en_one_cycle", {31'd0, regf_rd_en}, 32'd0);
        @(negedge clk);
        check("rd_latency", {31'd0, rsp_valid}, 32'd1);
        check("rsp_data", {24'd0, rsp_data}, {24'd0, ref_mem[ea]});
        check("rsp_last", {31'd0, rsp_last}, {31'd0, (cnt == exp_beats - 1)});
        check("wd_ready_in_rd", {31'd0, wd_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          check("hold_valid", {31'd0, rsp_valid}, 32'd1);
          check("hold_data", {24'd0, rsp_data}, {24'd0, ref_mem[ea]});
          check("hold_last", {31'd0, rsp_last}, {31'd0, (cnt == exp_beats - 1)});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cnt++;
        cyc += hold + 3;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    wd_valid = 1'b0;
    check("rd_timeout", {31'd0, (cyc >= 400)}, 32'd0);
    check("rd_beats", cnt, exp_beats);
    check("rd_idle_valid", {31'd0, rsp_valid}, 32'd0);
    check("rd_idle_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  typedef struct {
    bit rnw;
    int addr;
    int len;
    int dbase;
    int hold;
    int exp_beats;
  } vec_t;

  vec_t tbl[7];

  initial begin
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = 8'(i * 17);
      ref_mem[i] = 8'(i * 17);
    end
    tbl[0] = '{1'b0, 3,  0, 8'hA5, 0, 1};
    tbl[1] = '{1'b1, 3,  0, -1,    0, 1};
    tbl[2] = '{1'b0, 14, 3, 1,     0, BURST ? 4 : 1};
    tbl[3] = '{1'b1, 14, 3, -1,    1, BURST ? 4 : 1};
    tbl[4] = '{1'b1, 15, 1, -1,    5, BURST ? 2 : 1};
    tbl[5] = '{1'b0, 9,  7, -1,    0, BURST ? 8 : 1};
    tbl[6] = '{1'b1, 9,  7, -1,    2, BURST ? 8 : 1};

    // Reset state: every output low while reset is held.
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wd_ready", {31'd0, wd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_strobes", {30'd0, regf_wr_en, regf_rd_en}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].rnw) do_read(tbl[i].addr, tbl[i].len, tbl[i].hold, tbl[i].exp_beats);
      else            do_write(tbl[i].addr, tbl[i].len, tbl[i].dbase, tbl[i].exp_beats);
    end

    // Reset during the second beat of a len-3 write aborts the burst.
    issue_cmd(1'b0, 5, 3);
    if (BURST) begin
      wd_valid = 1'b1;
      wd_data  = 8'h3C;
      #1;
      check("abort_beat1", {31'd0, regf_wr_en}, 32'd1);
      ref_mem[5] = 8'h3C;
      @(negedge clk);
    end
    wd_valid = 1'b1;
    wd_data  = 8'h77;
    reset    = 1'b0;
    #1;
    check("abort_wr_en", {31'd0, regf_wr_en}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_wd_ready", {31'd0, wd_ready}, 32'd0);
    check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("abort_wr_en_held", {31'd0, regf_wr_en}, 32'd0);
    reset    = 1'b1;
    wd_valid = 1'b0;
    @(negedge clk);
    check("abort_ready_back", {31'd0, cmd_ready}, 32'd1);
    check("abort_idle", {31'd0, busy}, 32'd0);
    do_read(5, 1, 0, BURST ? 2 : 1);

    // Random commands against the array model.
    for (int i = 0; i < 24; i++) begin
      int a = $urandom_range(0, 15);
      int l = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) do_read(a, l, $urandom_range(0, 3), beats_of(l));
      else                           do_write(a, l, -1, beats_of(l));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regf_access_ctrl.md
REGF_ACCESS_CTRL -- requirements
Module: regf_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: register data width.
REQ-002 SHALL have parameter ADDR_W, default 4: register address width (16 entries).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-006 SHALL have port cmd_rnw  input  1  1 = read, 0 = write.
REQ-007 SHALL have port cmd_addr  input  ADDR_W  start address.
REQ-008 SHALL have port cmd_len  input  4  beats minus one (0 = single beat).
REQ-009 SHALL have ports wd_valid / wd_ready / wd_data  input / output / input  1 / 1 / DATA_W  write-data beats.
REQ-010 SHALL have ports rsp_valid / rsp_ready / rsp_data / rsp_last  output / input / output / output  1 / 1 / DATA_W / 1  read response.
REQ-011 SHALL have ports regf_wr_en, regf_rd_en, regf_wr_addr, regf_rd_addr, regf_data_in  output  1, 1, ADDR_W, ADDR_W, DATA_W  register-file drive.
REQ-012 SHALL have port regf_data_out  input  DATA_W  register-file read data, valid the cycle after regf_rd_en.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, WR, RD_ISSUE, RD_WAIT, RD_RESP.
REQ-015 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready, latch addr/len/rnw; go to WR (rnw=0) or RD_ISSUE (rnw=1).
REQ-016 WR: wd_ready=1; on each wd_valid&&wd_ready, assert regf_wr_en for that cycle, regf_wr_addr=current addr, regf_data_in=wd_data (combinational pass-through, zero latency).
REQ-017 RD_ISSUE: assert regf_rd_en for exactly one cycle with regf_rd_addr=current addr, then go to RD_WAIT.
REQ-018 RD_WAIT: capture regf_data_out into rsp_data register, go to RD_RESP.
REQ-019 RD_RESP: rsp_valid=1; rsp_data and rsp_last SHALL hold stable until rsp_ready; on handshake, go to RD_ISSUE (beats remain) or IDLE (last).
REQ-020 Read beat latency SHALL be: rsp_valid asserted 2 cycles after regf_rd_en; minimum 3 cycles per read beat.
REQ-021 After each beat, address SHALL increment modulo 2^ADDR_W (15 wraps to 0); beat counter decrements; last beat when counter = 0.
REQ-022 rsp_last SHALL be 1 on the final read beat only.
REQ-023 regf_wr_en and regf_rd_en SHALL never be 1 in the same cycle.
REQ-024 wd_ready SHALL be 0 outside WR; rsp_valid SHALL be 0 outside RD_RESP; wd beats outside WR are ignored.
REQ-025 A new command SHALL NOT be accepted until the prior burst completes.

Reset
REQ-026 On reset low, FSM SHALL go to IDLE immediately; all outputs 0 (cmd_ready becomes 1 after reset deasserts), address/counter/rsp_data cleared.
REQ-027 Reset mid-burst SHALL abort the burst with no further register-file strobes; remaining beats are discarded.

Configuration
REQ-028 With macro REGF_ACCESS_BURST_EN defined, cmd_len SHALL be honoured (1-16 beats).
REQ-029 Without REGF_ACCESS_BURST_EN, cmd_len SHALL be ignored; every command is one beat with rsp_last=1.

Verification
REQ-030 Reset, write addr 3 len 0 data 0xA5 -> one regf_wr_en, regf_wr_addr=3, regf_data_in=0xA5; back to IDLE.
REQ-031 Read addr 3 len 0, regfile returns 0xA5 -> regf_rd_en one cycle, rsp_valid 2 cycles later, rsp_data=0xA5, rsp_last=1.
REQ-032 Burst write addr 14 len 3 (BURST_EN) data 1,2,3,4 -> writes to 14,15,0,1 in order.
REQ-033 Burst read addr 15 len 1, rsp_ready low 5 cycles -> rsp_data held stable; beats from 15 then 0; rsp_last on second only.
REQ-034 Assert reset during beat 2 of len-3 write -> no further regf_wr_en; busy=0; next command accepted normally.
REQ-035 Without BURST_EN, write len 7 -> exactly one regf_wr_en; cmd_ready returns to 1.
